microwave_timer_ctrl: RTL and testbench
=======================================

MICROWAVE_TIMER_CTRL -- requirements
Module: microwave_timer_ctrl

Interface
REQ-001 SHALL have parameter TIME_W, default 8, width of cook-time counter in ticks.
REQ-002 SHALL have parameter PWR_LEVELS, default 4, number of power levels and PWM window length in ticks.
REQ-003 SHALL have parameter BELL_TICKS, default 3, bell duration in ticks (>=1).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port nrst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port tick  input  1  one-cycle time-base strobe, synchronous to clk.
REQ-007 SHALL have port door  input  1  door open level.
REQ-008 SHALL have port start  input  1  start/resume request, sampled each cycle.
REQ-009 SHALL have port cancel  input  1  abort request, sampled each cycle.
REQ-010 SHALL have port load  input  1  load set_time into countdown.
REQ-011 SHALL have port set_time  input  TIME_W  cook time in ticks.
REQ-012 SHALL have port power  input  $clog2(PWR_LEVELS)  power level, 0 lowest.
REQ-013 SHALL have ports heat, light, bell, busy  output  1 each; remaining  output  TIME_W  ticks left.

Function
REQ-014 SHALL implement states IDLE, COOK, PAUSE, OPEN, BELL; outputs are combinational decodes of registered state/counters.
REQ-015 IDLE: door -> OPEN; else load -> remaining<=set_time, stay; else start with remaining!=0 -> COOK with pwm_cnt<=0; start with remaining==0 ignored.
REQ-016 COOK priority door > cancel > tick: door -> PAUSE, no decrement; cancel -> IDLE, remaining<=0; tick -> remaining-1, pwm_cnt advances.
REQ-017 COOK: tick with remaining==1 -> remaining<=0 and BELL with bell_cnt<=0 on same edge.
REQ-018 PAUSE: cancel -> IDLE, remaining<=0; else door low and start -> COOK, pwm_cnt retained; ticks ignored.
REQ-019 OPEN: door low -> IDLE, remaining retained; load, start, cancel ignored while in OPEN.
REQ-020 BELL: door -> OPEN; else tick increments bell_cnt; tick with bell_cnt==BELL_TICKS-1 -> IDLE.
REQ-021 pwm_cnt SHALL count 0..PWR_LEVELS-1 on ticks in COOK, wrapping to 0.
REQ-022 heat SHALL be 1 only in COOK when pwm_cnt <= power; power=PWR_LEVELS-1 gives continuous heat.
REQ-023 light SHALL be 1 in COOK, PAUSE, OPEN; bell 1 only in BELL; busy 1 in COOK or PAUSE.
REQ-024 remaining SHALL never wrap below 0; load outside IDLE SHALL have no effect.
REQ-025 load and start in the same IDLE cycle: load wins, start ignored.

Reset
REQ-026 nrst low SHALL immediately force IDLE, remaining=0, pwm_cnt=0, bell_cnt=0; heat, light, bell, busy = 0.
REQ-027 Reset mid-COOK SHALL drop heat asynchronously, without waiting for clk.
REQ-028 After release with door high, state SHALL be OPEN after the first rising edge.

Configuration
REQ-029 With MW_CHILD_LOCK_EN defined, an input port lock (1 bit) SHALL exist; lock=1 SHALL suppress start and load in all states; door and cancel unaffected.
REQ-030 Without MW_CHILD_LOCK_EN, port lock SHALL be absent and behaviour SHALL be as if lock=0.

Verification
REQ-031 load set_time=3, start, power=3, 3 ticks -> heat=1 throughout COOK, remaining 3,2,1,0, then BELL for 3 ticks, then IDLE.
REQ-032 PWR_LEVELS=4, power=1, set_time=8 -> heat pattern per tick 1,1,0,0,1,1,0,0.
REQ-033 COOK remaining=5, door and tick same cycle -> PAUSE, remaining=5, heat=0, light=1; door low alone -> stays PAUSE; start -> COOK.
REQ-034 COOK, cancel and tick same cycle -> IDLE, remaining=0, busy=0; start with remaining=0 -> stays IDLE.
REQ-035 nrst low mid-COOK between edges -> heat=0, light=0 immediately; release with door=1 -> OPEN after one edge.
REQ-036 MW_CHILD_LOCK_EN defined, lock=1, load set_time=5 and start -> remaining=0, stays IDLE; cancel still works in COOK.

Source files
------------

// File: rtl/microwave_timer_ctrl.sv
// -----------------------------------------------------------------------------
// microwave_timer_ctrl
//
// Purpose: cook-cycle controller for a microwave oven. Counts a loaded cook
// time down on an external tick strobe. While cooking, it modulates the
// magnetron with a PWM window of PWR_LEVELS ticks. It pauses when the door
// opens, rings a bell for BELL_TICKS ticks when the countdown expires, and
// returns to idle afterwards.
//
// Ports:
//   clk        in   single clock, all state on the rising edge
//   nrst       in   asynchronous active-low reset
//   tick       in   one-cycle time-base strobe, synchronous to clk
//   door       in   door-open level
//   start      in   start / resume request
//   cancel     in   abort request
//   load       in   load set_time into the countdown (idle only)
//   set_time   in   [TIME_W-1:0] cook time in ticks
//   power      in   [$clog2(PWR_LEVELS)-1:0] power level, 0 lowest
//   lock       in   child lock, present only with MW_CHILD_LOCK_EN defined
//   heat       out  magnetron enable
//   light      out  cavity lamp
//   bell       out  end-of-cook bell
//   busy       out  a cook cycle is in progress (cooking or paused)
//   remaining  out  [TIME_W-1:0] ticks left
//
// Configuration macro: MW_CHILD_LOCK_EN adds the lock input. When lock is
// high, start and load are masked in every state. Without the macro, the
// port is absent and the lock is treated as permanently released.
//
// All outputs are decoded combinationally from registered state. Asserting
// the reset therefore clears them at once, without waiting for a clock edge.
// -----------------------------------------------------------------------------
module microwave_timer_ctrl #(
  parameter int TIME_W     = 8,
  parameter int PWR_LEVELS = 4,
  parameter int BELL_TICKS = 3
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          tick,
  input  logic                          door,
  input  logic                          start,
  input  logic                          cancel,
  input  logic                          load,
  input  logic [TIME_W-1:0]             set_time,
  input  logic [$clog2(PWR_LEVELS)-1:0] power,
`ifdef MW_CHILD_LOCK_EN
  input  logic                          lock,
`endif
  output logic                          heat,
  output logic                          light,
  output logic                          bell,
  output logic                          busy,
  output logic [TIME_W-1:0]             remaining
);

  localparam int PWR_W  = $clog2(PWR_LEVELS);
  localparam int BELL_W = (BELL_TICKS > 1) ? $clog2(BELL_TICKS) : 1;

  localparam logic [PWR_W-1:0]  PWM_LAST  = PWR_W'(PWR_LEVELS - 1);
  localparam logic [BELL_W-1:0] BELL_LAST = BELL_W'(BELL_TICKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COOK  = 3'd1,
    ST_PAUSE = 3'd2,
    ST_OPEN  = 3'd3,
    ST_BELL  = 3'd4
  } state_t;

  state_t              state_q,     state_d;
  logic [TIME_W-1:0]   remaining_q, remaining_d;
  logic [PWR_W-1:0]    pwm_cnt_q,   pwm_cnt_d;
  logic [BELL_W-1:0]   bell_cnt_q,  bell_cnt_d;

  logic lock_i;
  logic start_ok;
  logic load_ok;

  // Countdown step that holds at zero instead of wrapping.
  function automatic logic [TIME_W-1:0] sat_dec(input logic [TIME_W-1:0] v);
    sat_dec = (v == '0) ? v : v - TIME_W'(1);
  endfunction

  // The PWM phase runs 0..PWR_LEVELS-1 and wraps.
  function automatic logic [PWR_W-1:0] pwm_next(input logic [PWR_W-1:0] v);
    pwm_next = (v == PWM_LAST) ? '0 : v + PWR_W'(1);
  endfunction

`ifdef MW_CHILD_LOCK_EN
  assign lock_i = lock;
`else
  assign lock_i = 1'b0;
`endif

  // The lock masks only the two requests that could start the oven or change
  // the countdown. Door and cancel stay live for safety.
  assign start_ok = start & ~lock_i;
  assign load_ok  = load  & ~lock_i;

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      pwm_cnt_q   <= '0;
      bell_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      pwm_cnt_q   <= pwm_cnt_d;
      bell_cnt_q  <= bell_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    pwm_cnt_d   = pwm_cnt_q;
    bell_cnt_d  = bell_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (door) begin
          state_d = ST_OPEN;
        end else if (load_ok) begin
          // load takes priority over a simultaneous start
          remaining_d = set_time;
        end else if (start_ok && (remaining_q != '0)) begin
          state_d   = ST_COOK;
          pwm_cnt_d = '0;
        end
      end

      ST_COOK: begin
        if (door) begin
          // the tick in this cycle is discarded; remaining stays untouched
          state_d = ST_PAUSE;
        end else if (cancel) begin
          state_d     = ST_IDLE;
          remaining_d = '0;
        end else if (tick) begin
          pwm_cnt_d = pwm_next(pwm_cnt_q);
          if (remaining_q <= TIME_W'(1)) begin
            remaining_d = '0;
            state_d     = ST_BELL;
            bell_cnt_d  = '0;
          end else begin
            remaining_d = sat_dec(remaining_q);
          end
        end
      end

      ST_PAUSE: begin
        if (cancel) begin
          state_d     = ST_IDLE;
          remaining_d = '0;
        end else if (!door && start_ok) begin
          // resume keeps the PWM phase where it was interrupted
          state_d = ST_COOK;
        end
      end

      ST_OPEN: begin
        if (!door) begin
          state_d = ST_IDLE;
        end
      end

      ST_BELL: begin
        if (door) begin
          state_d = ST_OPEN;
        end else if (tick) begin
          if (bell_cnt_q == BELL_LAST) begin
            state_d = ST_IDLE;
          end else begin
            bell_cnt_d = bell_cnt_q + BELL_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    heat  = 1'b0;
    light = 1'b0;
    bell  = 1'b0;
    busy  = 1'b0;

    unique case (state_q)
      ST_COOK: begin
        // pwm_cnt never exceeds PWM_LAST, so the top power level heats
        // continuously
        heat  = (pwm_cnt_q <= power);
        light = 1'b1;
        busy  = 1'b1;
      end
      ST_PAUSE: begin
        light = 1'b1;
        busy  = 1'b1;
      end
      ST_OPEN: begin
        light = 1'b1;
      end
      ST_BELL: begin
        bell = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign remaining = remaining_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
module tb_microwave_timer_ctrl;

  logic       clk;
  logic       nrst;
  logic       tick;
  logic       door;
  logic       start;
  logic       cancel;
  logic       load;
  logic [7:0] set_time;
  logic [1:0] power;
`ifdef MW_CHILD_LOCK_EN
  logic       lock;
`endif
  logic       heat;
  logic       light;
  logic       bell;
  logic       busy;
  logic [7:0] remaining;

  int n_cmp;
  int n_bad;

  microwave_timer_ctrl #(
    .TIME_W    (8),
    .PWR_LEVELS(4),
    .BELL_TICKS(3)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .tick     (tick),
    .door     (door),
    .start    (start),
    .cancel   (cancel),
    .load     (load),
    .set_time (set_time),
    .power    (power),
`ifdef MW_CHILD_LOCK_EN
    .lock     (lock),
`endif
    .heat     (heat),
    .light    (light),
    .bell     (bell),
    .busy     (busy),
    .remaining(remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       d, s, c, l, t;
    logic [7:0] st;
    logic [1:0] pw;
    logic       h, li, b, bu;
    logic [7:0] rem;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic d, s, c, l, t,
                              input logic [7:0] st, input logic [1:0] pw,
                              input logic h, li, b, bu,
                              input logic [7:0] rem);
    vec_t v;
    v.d = d; v.s = s; v.c = c; v.l = l; v.t = t;
    v.st = st; v.pw = pw;
    v.h = h; v.li = li; v.b = b; v.bu = bu; v.rem = rem;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic h, li, b, bu,
                         input logic [7:0] rem);
    chk({tag, ".heat"},      32'(heat),      32'(h));
    chk({tag, ".light"},     32'(light),     32'(li));
    chk({tag, ".bell"},      32'(bell),      32'(b));
    chk({tag, ".busy"},      32'(busy),      32'(bu));
    chk({tag, ".remaining"}, 32'(remaining), 32'(rem));
  endtask

  task automatic drive(input logic d, s, c, l, t, input logic [7:0] st,
                       input logic [1:0] pw);
    door = d; start = s; cancel = c; load = l; tick = t;
    set_time = st; power = pw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    nrst  = 1'b0;
`ifdef MW_CHILD_LOCK_EN
    lock  = 1'b0;
`endif
    drive(0, 0, 0, 0, 0, 8'd0, 2'd0);

    //           d s c l t  set  pw   h li b bu rem
    // load/start priority, full-power cook, bell expiry
    vecs.push_back(mk(0,0,0,1,0, 8'd3, 2'd3, 0,0,0,0, 8'd3));
    vecs.push_back(mk(0,1,0,1,0, 8'd7, 2'd3, 0,0,0,0, 8'd7));
    vecs.push_back(mk(0,0,0,1,0, 8'd3, 2'd3, 0,0,0,0, 8'd3));
    vecs.push_back(mk(0,1,0,0,0, 8'd0, 2'd3, 1,1,0,1, 8'd3));
    vecs.push_back(mk(0,0,0,0,1, 8'd0, 2'd3, 1,1,0,1, 8'd2));
    vecs.push_back(mk(0,0,0,1,0, 8'd9, 2'd3, 1,1,0,1, 8'd2));
    vecs.push_back(mk(0,0,0,0,1, 8'd0, 2'd3, 1,1,0,1, 8'd1));
    vecs.push_back(mk(0,0,0,0,1, 8'd0, 2'd3, 0,0,1,0, 8'd0));
    vecs.push_back(mk(0,0,0,0,1, 8'd0, 2'd3, 0,0,1,0, 8'd0));
    vecs.push_back(mk(0,0,0,0,0, 8'd0, 2'd3, 0,0,1,0, 8'd0));
    vecs.push_back(mk(0,0,0,0,1, 8'd0, 2'd3, 0,0,1,0, 8'd0));
    vecs.push_back(mk(0,0,0,0,1, 8'd0, 2'd3, 0,0,0,0, 8'd0));
    vecs.push_back(mk(0,1,0,0,0, 8'd0, 2'd3, 0,0,0,0, 8'd0));
    // power=1 PWM pattern 1,1,0,0,1,1,0,0
    vecs.push_back(mk(0,0,0,1,0, 8'd8, 2'd1, 0,0,0,0, 8'd8));
    vecs.push_back(mk(0,1,0,0,0, 8'd0, 2'd1, 1,1,0,1, 8'd8));
    vecs.push_back(mk(0,0,0,0,1, 8'd0, 2'd1, 1,1,0,1, 8'd7));
    vecs.push_back(mk(0,0,0,0,1, 8'd0, 2'd1, 0,1,0,1, 8'd6));
    vecs.push_back(mk(0,0,0,0,1, 8'd0, 2'd1, 0,1,0,1, 8'd5));
    vecs.push_back(mk(0,0,0,0,1, 8'd0, 2'd1, 1,1,0,1, 8'd4));
    vecs.push_back(mk(0,0,0,0,1, 8'd0, 2'd1, 1,1,0,1, 8'd3));
    vecs.push_back(mk(0,0,0,0,1, 8'd0, 2'd1, 0,1,0,1, 8'd2));
    vecs.push_back(mk(0,0,0,0,1, 8'd0, 2'd1, 0,1,0,1, 8'd1));
    vecs.push_back(mk(0,0,0,0,1, 8'd0, 2'd1, 0,0,1,0, 8'd0));
    // door during bell, open ignores load/start/cancel
    vecs.push_back(mk(1,0,0,0,0, 8'd0, 2'd1, 0,1,0,0, 8'd0));
    vecs.push_back(mk(1,1,1,1,0, 8'd4, 2'd1, 0,1,0,0, 8'd0));
    vecs.push_back(mk(0,0,0,0,0, 8'd0, 2'd1, 0,0,0,0, 8'd0));
    // door+tick pause, resume, cancel+tick
    vecs.push_back(mk(0,0,0,1,0, 8'd5, 2'd3, 0,0,0,0, 8'd5));
    vecs.push_back(mk(0,1,0,0,0, 8'd0, 2'd3, 1,1,0,1, 8'd5));
    vecs.push_back(mk(1,0,0,0,1, 8'd0, 2'd3, 0,1,0,1, 8'd5));
    vecs.push_back(mk(0,0,0,0,1, 8'd0, 2'd3, 0,1,0,1, 8'd5));
    vecs.push_back(mk(0,1,0,0,0, 8'd0, 2'd3, 1,1,0,1, 8'd5));
    vecs.push_back(mk(0,0,0,0,1, 8'd0, 2'd3, 1,1,0,1, 8'd4));
    vecs.push_back(mk(0,0,1,0,1, 8'd0, 2'd3, 0,0,0,0, 8'd0));
    vecs.push_back(mk(0,1,0,0,0, 8'd0, 2'd3, 0,0,0,0, 8'd0));
    // open retains remaining; power 0; cancel in pause beats door
    vecs.push_back(mk(0,0,0,1,0, 8'd6, 2'd0, 0,0,0,0, 8'd6));
    vecs.push_back(mk(1,0,0,0,0, 8'd0, 2'd0, 0,1,0,0, 8'd6));
    vecs.push_back(mk(1,1,0,0,0, 8'd0, 2'd0, 0,1,0,0, 8'd6));
    vecs.push_back(mk(0,1,0,0,0, 8'd0, 2'd0, 0,0,0,0, 8'd6));
    vecs.push_back(mk(0,1,0,0,0, 8'd0, 2'd0, 1,1,0,1, 8'd6));
    vecs.push_back(mk(0,0,0,0,1, 8'd0, 2'd0, 0,1,0,1, 8'd5));
    vecs.push_back(mk(1,0,0,0,0, 8'd0, 2'd0, 0,1,0,1, 8'd5));
    vecs.push_back(mk(1,0,1,0,0, 8'd0, 2'd0, 0,0,0,0, 8'd0));
    vecs.push_back(mk(0,0,0,0,0, 8'd0, 2'd0, 0,0,0,0, 8'd0));
    // one-tick cook, door during bell
    vecs.push_back(mk(0,0,0,1,0, 8'd1, 2'd3, 0,0,0,0, 8'd1));
    vecs.push_back(mk(0,1,0,0,0, 8'd0, 2'd3, 1,1,0,1, 8'd1));
    vecs.push_back(mk(0,0,0,0,1, 8'd0, 2'd3, 0,0,1,0, 8'd0));
    vecs.push_back(mk(1,0,0,0,0, 8'd0, 2'd3, 0,1,0,0, 8'd0));
    vecs.push_back(mk(0,0,0,0,0, 8'd0, 2'd3, 0,0,0,0, 8'd0));

    // reset state, held asynchronously before any clock edge
    #1;
    chk_out("reset", 0, 0, 0, 0, 8'd0);
    step();
    nrst = 1'b1;
    step();
    chk_out("post_reset", 0, 0, 0, 0, 8'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].d, vecs[i].s, vecs[i].c, vecs[i].l, vecs[i].t,
            vecs[i].st, vecs[i].pw);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].h, vecs[i].li, vecs[i].b,
              vecs[i].bu, vecs[i].rem);
    end

    // asynchronous reset in the middle of a cook
    drive(0, 0, 0, 1, 0, 8'd4, 2'd3); step();
    drive(0, 1, 0, 0, 0, 8'd0, 2'd3); step();
    drive(0, 0, 0, 0, 1, 8'd0, 2'd3); step();
    chk_out("rst_pre", 1, 1, 0, 1, 8'd3);
    drive(0, 0, 0, 0, 0, 8'd0, 2'd3);
    #2 nrst = 1'b0;
    #1;
    chk_out("rst_async", 0, 0, 0, 0, 8'd0);
    door = 1'b1;
    step();
    chk_out("rst_held", 0, 0, 0, 0, 8'd0);
    #2 nrst = 1'b1;
    step();
    chk_out("rst_open", 0, 1, 0, 0, 8'd0);
    door = 1'b0;
    step();
    chk_out("rst_idle", 0, 0, 0, 0, 8'd0);

`ifdef MW_CHILD_LOCK_EN
    // locked: load and start masked
    lock = 1'b1;
    drive(0, 1, 0, 1, 0, 8'd5, 2'd3); step();
    chk_out("lock_load", 0, 0, 0, 0, 8'd0);
    drive(0, 1, 0, 0, 0, 8'd0, 2'd3); step();
    chk_out("lock_start", 0, 0, 0, 0, 8'd0);
    lock = 1'b0;
    drive(0, 0, 0, 1, 0, 8'd5, 2'd3); step();
    drive(0, 1, 0, 0, 0, 8'd0, 2'd3); step();
    chk_out("lock_cook", 1, 1, 0, 1, 8'd5);
    lock = 1'b1;
    drive(0, 0, 1, 0, 0, 8'd0, 2'd3); step();
    chk_out("lock_cancel", 0, 0, 0, 0, 8'd0);
    lock = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
